spi_ram_burst: RTL and testbench
================================

# spi_ram_burst

Parametrised command-driven single-port RAM that sits behind the SPI slave deserialiser. It generalises the fixed 8-bit/256-word command RAM to configurable data width, address width and depth. It adds auto-incrementing burst addressing, range checking and a tx_valid/tx_ready output handshake with overrun detection. The block accepts one 2-bit-tagged command word per rx_valid cycle and returns read data to the SPI serialiser.

## Interface
- DATA_W, 8, data and payload width in bits.
- ADDR_W, 8, address register width; must satisfy ADDR_W <= DATA_W.
- MEM_DEPTH, 256, number of words; must satisfy MEM_DEPTH <= 2**ADDR_W.
- AUTO_INC, 1, 1 = post-increment wr_addr/rd_addr on data commands; 0 = addresses hold.

- clk  in  1  clock, rising-edge active.
- rst_n  in  1  reset, asynchronous, active-low.
- din  in  DATA_W+2  command word: din[DATA_W+1:DATA_W] = cmd, din[DATA_W-1:0] = payload.
- rx_valid  in  1  din valid this cycle; one command consumed per cycle while high.
- tx_ready  in  1  consumer accepts dout this cycle.
- clr_err  in  1  synchronous clear of addr_err and overrun.
- dout  out  DATA_W  read data, held stable while tx_valid=1 and tx_ready=0.
- tx_valid  out  1  dout holds unconsumed read data.
- addr_err  out  1  sticky: an out-of-range address was loaded.
- overrun  out  1  sticky: a read command was dropped because the output slot was full.

## Operation
- Reset values: dout=0, tx_valid=0, addr_err=0, overrun=0, wr_addr=0, rd_addr=0. Memory is not reset and keeps its contents through a mid-operation reset.
- Commands are decoded only when rx_valid=1. An address payload is payload[ADDR_W-1:0].
- cmd 00, set write address: if payload >= MEM_DEPTH, set addr_err and leave wr_addr unchanged; else wr_addr <= payload.
- cmd 01, write: mem[wr_addr] <= payload. If AUTO_INC=1, wr_addr advances by 1 and wraps from MEM_DEPTH-1 to 0.
- cmd 10, set read address: same range rule as cmd 00, applied to rd_addr.
- cmd 11, read: the output slot is free when tx_valid=0 or tx_ready=1.
  - Slot free: dout <= mem[rd_addr], tx_valid <= 1. If AUTO_INC=1, rd_addr advances by 1 with wrap.
  - Slot not free: overrun <= 1, command dropped, rd_addr unchanged, dout/tx_valid unchanged.
- Handshake: when tx_valid=1 and tx_ready=1 with no accepted read in the same cycle, tx_valid <= 0 next cycle. dout keeps its last value.
- Simultaneous tx_ready=1 and accepted read: the new data loads and tx_valid stays 1 (back-to-back reads at full rate).
- clr_err=1 clears both flags. If clr_err=1 and a new error occur in the same cycle, the error wins and the flag stays set.
- Wrap uses MEM_DEPTH, not 2**ADDR_W. Non-power-of-two depths wrap at MEM_DEPTH-1.

## Timing
- Every state element updates on the rising clk edge, except reset, which acts immediately on the rst_n falling edge.
- Read latency: a cmd 11 accepted at edge N drives dout/tx_valid valid after edge N (1 cycle).
- Write-then-read: a write at edge N followed by a read of the same address at edge N+1 returns the new data.
- Address commands take effect for the data command on the next cycle.
- addr_err and overrun assert after the offending edge.
- rx_valid=0 cycles change only the tx handshake state and the flags (via clr_err).

## Test plan
- Burst write then read, DATA_W=8, MEM_DEPTH=256:
  - Stimulus: cmd00 0x10; cmd01 0xA1,0xA2,0xA3; cmd10 0x10; three cmd11 with tx_ready=1.
  - Required: dout = 0xA1,0xA2,0xA3 on consecutive cycles; tx_valid stays high for 3 cycles, then low.
- Wrap, MEM_DEPTH=200:
  - Stimulus: cmd00 199; cmd01 0x55,0x66; cmd10 0; cmd11.
  - Required: dout=0x66 (second write wrapped to address 0); mem[199]=0x55.
- Range error:
  - Stimulus: cmd00 200 with MEM_DEPTH=200.
  - Required: addr_err=1 and wr_addr unchanged; clr_err pulse then returns addr_err to 0.
- Backpressure:
  - Stimulus: tx_ready=0; cmd11 at rd_addr 5, then cmd11 again.
  - Required: first read sets tx_valid=1 with mem[5]; second read sets overrun=1, dout unchanged, rd_addr=6.
  - Then tx_ready=1: tx_valid drops the next cycle.
- Reset mid-burst:
  - Stimulus: assert rst_n=0 between two cmd01 writes; release; cmd10 to the first address; cmd11.
  - Required: all outputs and both addresses read 0 during reset; the first written value is still read back.
- AUTO_INC=0:
  - Stimulus: cmd00 3; cmd01 0x11, 0x22; cmd10 3; cmd11 twice.
  - Required: dout=0x22 on both reads.

Source files
------------

// File: rtl/spi_ram_burst.sv
// spi_ram_burst
// Command-driven single-port RAM behind the SPI slave deserialiser. Each
// rx_valid cycle consumes one tagged command word; reads are returned through
// a one-entry output slot with a tx_valid/tx_ready handshake.
//
// Parameters
//   DATA_W    data/payload width (ADDR_W <= DATA_W)
//   ADDR_W    address register width (MEM_DEPTH <= 2**ADDR_W)
//   MEM_DEPTH number of words; address wrap point is MEM_DEPTH-1
//   AUTO_INC  1 = post-increment wr_addr/rd_addr on data commands
//
// Ports
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   din         {cmd[1:0], payload[DATA_W-1:0]}
//               cmd 00 set wr_addr, 01 write, 10 set rd_addr, 11 read
//   rx_valid    din valid; one command per cycle
//   tx_ready    consumer takes dout this cycle
//   clr_err     synchronous clear of addr_err/overrun (a same-cycle error wins)
//   dout        read data; held stable while tx_valid && !tx_ready
//   tx_valid    dout holds unconsumed read data
//   addr_err    sticky: out-of-range address command seen
//   overrun     sticky: read dropped because the output slot was full
//
// Handshake: a transfer happens on every rising edge where tx_valid && tx_ready.
// The slot is free for a new read when !tx_valid || tx_ready, so a read can
// refill the slot in the same cycle it is drained (full-rate back-to-back reads).
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter bit AUTO_INC  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  input  logic              tx_ready,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              addr_err,
  output logic              overrun
);

  // One extra bit so MEM_DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  localparam logic [1:0] CMD_SET_WR = 2'b00;
  localparam logic [1:0] CMD_WRITE  = 2'b01;
  localparam logic [1:0] CMD_SET_RD = 2'b10;
  localparam logic [1:0] CMD_READ   = 2'b11;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [ADDR_W-1:0] wr_addr, wr_addr_n;
  logic [ADDR_W-1:0] rd_addr, rd_addr_n;
  logic              tx_valid_n, addr_err_n, overrun_n;
  logic              mem_we, rd_load;

  logic [1:0]        cmd;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] addr_pl;
  logic              in_range;
  logic              slot_free;

  assign cmd       = din[DATA_W+1:DATA_W];
  assign payload   = din[DATA_W-1:0];
  assign addr_pl   = payload[ADDR_W-1:0];
  assign in_range  = ({1'b0, addr_pl} < DEPTH_EXT);
  assign slot_free = !tx_valid || tx_ready;

  // Wrap at MEM_DEPTH-1, which need not be a power of two.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  always_comb begin
    wr_addr_n  = wr_addr;
    rd_addr_n  = rd_addr;
    tx_valid_n = tx_valid;
    addr_err_n = addr_err;
    overrun_n  = overrun;
    mem_we     = 1'b0;
    rd_load    = 1'b0;

    // Clear first so an error raised below in the same cycle overrides it.
    if (clr_err) begin
      addr_err_n = 1'b0;
      overrun_n  = 1'b0;
    end

    if (tx_valid && tx_ready) tx_valid_n = 1'b0;

    if (rx_valid) begin
      case (cmd)
        CMD_SET_WR: begin
          if (in_range) wr_addr_n  = addr_pl;
          else          addr_err_n = 1'b1;
        end
        CMD_WRITE: begin
          mem_we = 1'b1;
          if (AUTO_INC) wr_addr_n = next_addr(wr_addr);
        end
        CMD_SET_RD: begin
          if (in_range) rd_addr_n  = addr_pl;
          else          addr_err_n = 1'b1;
        end
        CMD_READ: begin
          if (slot_free) begin
            rd_load    = 1'b1;
            tx_valid_n = 1'b1;
            if (AUTO_INC) rd_addr_n = next_addr(rd_addr);
          end else begin
            overrun_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
      addr_err <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      wr_addr  <= wr_addr_n;
      rd_addr  <= rd_addr_n;
      tx_valid <= tx_valid_n;
      addr_err <= addr_err_n;
      overrun  <= overrun_n;
      if (rd_load) dout <= mem[rd_addr];
    end
  end

  // Storage deliberately has no reset: contents survive a mid-operation reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= payload;
  end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Bench for spi_ram_burst. Two instances share one stimulus stream:
//   u0: MEM_DEPTH=200, AUTO_INC=1
//   u1: MEM_DEPTH=256, AUTO_INC=0
// A behavioural model per instance tracks the expected outputs; a compare
// process checks every cycle, and directed literal checks pin key values.
module tb_spi_ram_burst;

  logic       clk;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic       tx_ready;
  logic       clr_err;

  logic [7:0] dout0, dout1;
  logic       tv0, tv1, ae0, ae1, ov0, ov1;

  int n_checks;
  int n_errors;

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .clr_err(clr_err), .dout(dout0), .tx_valid(tv0), .addr_err(ae0), .overrun(ov0)
  );

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .clr_err(clr_err), .dout(dout1), .tx_valid(tv1), .addr_err(ae1), .overrun(ov1)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         depth [2];
  bit         inc   [2];
  logic [7:0] m_mem [2][256];
  bit         m_wr  [2][256];
  logic [7:0] m_dout  [2];
  bit         m_known [2];
  bit         m_tv [2];
  bit         m_ae [2];
  bit         m_ov [2];
  int         m_wa [2];
  int         m_ra [2];

  initial begin
    depth[0] = 200; inc[0] = 1'b1;
    depth[1] = 256; inc[1] = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) begin
        m_wr[k][a]  = 1'b0;
        m_mem[k][a] = 8'h00;
      end
  end

  task automatic model_step(input int k);
    int c;
    int pl;
    bit slot;
    c    = int'(din[9:8]);
    pl   = int'(din[7:0]);
    slot = !m_tv[k] || tx_ready;
    if (m_tv[k] && tx_ready) m_tv[k] = 1'b0;
    if (clr_err) begin
      m_ae[k] = 1'b0;
      m_ov[k] = 1'b0;
    end
    if (rx_valid) begin
      case (c)
        0: if (pl < depth[k]) m_wa[k] = pl; else m_ae[k] = 1'b1;
        1: begin
          m_mem[k][m_wa[k]] = din[7:0];
          m_wr[k][m_wa[k]]  = 1'b1;
          if (inc[k]) m_wa[k] = (m_wa[k] + 1) % depth[k];
        end
        2: if (pl < depth[k]) m_ra[k] = pl; else m_ae[k] = 1'b1;
        default: begin
          if (slot) begin
            m_dout[k]  = m_mem[k][m_ra[k]];
            m_known[k] = m_wr[k][m_ra[k]];
            m_tv[k]    = 1'b1;
            if (inc[k]) m_ra[k] = (m_ra[k] + 1) % depth[k];
          end else begin
            m_ov[k] = 1'b1;
          end
        end
      endcase
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_dout[k] = 8'h00; m_known[k] = 1'b1; m_tv[k] = 1'b0;
        m_ae[k] = 1'b0; m_ov[k] = 1'b0; m_wa[k] = 0; m_ra[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("u0.tx_valid", 32'(tv0), 32'(m_tv[0]));
    chk("u0.addr_err", 32'(ae0), 32'(m_ae[0]));
    chk("u0.overrun",  32'(ov0), 32'(m_ov[0]));
    if (m_known[0]) chk("u0.dout", 32'(dout0), 32'(m_dout[0]));
    chk("u1.tx_valid", 32'(tv1), 32'(m_tv[1]));
    chk("u1.addr_err", 32'(ae1), 32'(m_ae[1]));
    chk("u1.overrun",  32'(ov1), 32'(m_ov[1]));
    if (m_known[1]) chk("u1.dout", 32'(dout1), 32'(m_dout[1]));
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; applies inputs for the next edge and
  // returns #1 after it, so outputs then reflect this command.
  task automatic issue(input logic [1:0] c, input logic [7:0] p);
    rx_valid = 1'b1;
    din      = {c, p};
    clr_err  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit clr);
    rx_valid = 1'b0;
    din      = '0;
    clr_err  = clr;
    @(posedge clk); #1;
    clr_err  = 1'b0;
  endtask

  task automatic issue_clr(input logic [1:0] c, input logic [7:0] p);
    rx_valid = 1'b1;
    din      = {c, p};
    clr_err  = 1'b1;
    @(posedge clk); #1;
    clr_err  = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    din      = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    clr_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst dout0", 32'(dout0), 32'h0);
    chk("rst tv0",   32'(tv0),   32'h0);
    chk("rst ae0",   32'(ae0),   32'h0);
    chk("rst ov0",   32'(ov0),   32'h0);
    chk("rst dout1", 32'(dout1), 32'h0);
    rst_n = 1'b1;

    // Burst write then read at full rate.
    tx_ready = 1'b1;
    issue(2'b00, 8'h10);
    issue(2'b01, 8'hA1);
    issue(2'b01, 8'hA2);
    issue(2'b01, 8'hA3);
    issue(2'b10, 8'h10);
    issue(2'b11, 8'h00);
    chk("burst r0 dout0", 32'(dout0), 32'hA1);
    chk("burst r0 tv0",   32'(tv0),   32'h1);
    chk("burst r0 dout1", 32'(dout1), 32'hA3);
    issue(2'b11, 8'h00);
    chk("burst r1 dout0", 32'(dout0), 32'hA2);
    chk("burst r1 tv0",   32'(tv0),   32'h1);
    issue(2'b11, 8'h00);
    chk("burst r2 dout0", 32'(dout0), 32'hA3);
    chk("burst r2 tv0",   32'(tv0),   32'h1);
    idle(1'b0);
    chk("burst drain tv0",   32'(tv0),   32'h0);
    chk("burst hold dout0",  32'(dout0), 32'hA3);

    // Wrap at MEM_DEPTH-1 = 199 on u0.
    issue(2'b00, 8'd199);
    issue(2'b01, 8'h55);
    issue(2'b01, 8'h66);
    issue(2'b10, 8'd0);
    issue(2'b11, 8'h00);
    chk("wrap addr0 dout0", 32'(dout0), 32'h66);
    issue(2'b10, 8'd199);
    issue(2'b11, 8'h00);
    chk("wrap addr199 dout0", 32'(dout0), 32'h55);

    // Range error: u0 wr_addr must stay at 1 (post-wrap).
    issue(2'b00, 8'd200);
    chk("range ae0", 32'(ae0), 32'h1);
    chk("range ae1", 32'(ae1), 32'h0);
    issue(2'b01, 8'h77);
    issue(2'b10, 8'd1);
    issue(2'b11, 8'h00);
    chk("range wr_addr kept dout0", 32'(dout0), 32'h77);
    idle(1'b1);
    chk("clr ae0", 32'(ae0), 32'h0);
    issue_clr(2'b00, 8'd250);
    chk("clr vs error ae0", 32'(ae0), 32'h1);
    chk("clr vs error ae1", 32'(ae1), 32'h0);
    idle(1'b1);
    chk("clr2 ae0", 32'(ae0), 32'h0);

    // Backpressure and overrun.
    issue(2'b00, 8'd5);
    issue(2'b01, 8'h5A);
    issue(2'b01, 8'h5B);
    tx_ready = 1'b0;
    issue(2'b10, 8'd5);
    issue(2'b11, 8'h00);
    chk("bp r0 tv0",   32'(tv0),   32'h1);
    chk("bp r0 dout0", 32'(dout0), 32'h5A);
    issue(2'b11, 8'h00);
    chk("bp overrun ov0", 32'(ov0),   32'h1);
    chk("bp hold dout0",  32'(dout0), 32'h5A);
    chk("bp hold tv0",    32'(tv0),   32'h1);
    tx_ready = 1'b1;
    idle(1'b0);
    chk("bp drain tv0", 32'(tv0), 32'h0);
    issue(2'b11, 8'h00);
    chk("bp rd_addr kept dout0", 32'(dout0), 32'h5B);
    chk("bp dout1",              32'(dout1), 32'h5B);
    idle(1'b1);
    chk("clr ov0", 32'(ov0), 32'h0);

    // Reset between two writes; memory contents survive.
    issue(2'b00, 8'h20);
    issue(2'b01, 8'hC1);
    rst_n = 1'b0;
    rx_valid = 1'b0;
    #1;
    chk("midrst dout0", 32'(dout0), 32'h0);
    chk("midrst tv0",   32'(tv0),   32'h0);
    chk("midrst dout1", 32'(dout1), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(2'b01, 8'hC2);
    issue(2'b10, 8'h20);
    issue(2'b11, 8'h00);
    chk("midrst keep dout0", 32'(dout0), 32'hC1);
    chk("midrst keep dout1", 32'(dout1), 32'hC1);
    issue(2'b10, 8'h00);
    issue(2'b11, 8'h00);
    chk("midrst wr_addr0 dout0", 32'(dout0), 32'hC2);

    // Fixed addressing on u1.
    issue(2'b00, 8'd3);
    issue(2'b01, 8'h11);
    issue(2'b01, 8'h22);
    issue(2'b10, 8'd3);
    issue(2'b11, 8'h00);
    chk("noinc r0 dout1", 32'(dout1), 32'h22);
    chk("noinc r0 dout0", 32'(dout0), 32'h11);
    issue(2'b11, 8'h00);
    chk("noinc r1 dout1", 32'(dout1), 32'h22);
    chk("noinc r1 dout0", 32'(dout0), 32'h22);
    idle(1'b0);
    chk("noinc drain tv1", 32'(tv1), 32'h0);
    idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
